cr_field_file: RTL and testbench

//  Parametrised condition register: NFIELD fields of FW bits each.

---
 rtl/cr_field_file.sv | 129 ++++++++++++
 tb/tb_cr_field_file.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cr_field_file.sv
`timescale 1ns/1ps
// Multi-field condition register: masked field writes, bypassed field reads, per-field pending-write scoreboard.
// Latency: writes land in cr_all one cycle later; rd_data is combinational (same-cycle write forwarded).
// Backpressure: none; every write, reservation and read is accepted every cycle, overflow/underflow flagged sticky.
module cr_field_file #(
  parameter int NFIELD = 8,
  parameter int FW     = 4,
  parameter int NWP    = 2,
  parameter int NRP    = 2,
  parameter int PW     = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NWP-1:0]                wr_en,
  input  logic [NWP*NFIELD-1:0]         wr_mask,
  input  logic [NWP*NFIELD*FW-1:0]      wr_data,
  input  logic                          rsv_en,
  input  logic [NFIELD-1:0]             rsv_mask,
  input  logic [NRP*$clog2(NFIELD)-1:0] rd_sel,
  output logic [NRP*FW-1:0]             rd_data,
  output logic [NRP-1:0]                rd_busy,
  output logic [NFIELD*FW-1:0]          cr_all,
  output logic [NFIELD-1:0]             busy,
  output logic                          err_ovf,
  output logic                          err_unf
);

  localparam int SELW = $clog2(NFIELD);
  // Count arithmetic carries two extra bits: one for the +1 headroom, one as sign.
  localparam int CW   = PW + 2;
  localparam logic [CW-1:0] CMAX = CW'((1 << PW) - 1);

  logic [NFIELD*FW-1:0] cr_q;
  logic [NFIELD*FW-1:0] cr_nxt;
  logic [NFIELD-1:0]    wr_hit [NWP];
  logic [PW-1:0]        cnt_q   [NFIELD];
  logic [PW-1:0]        cnt_nxt [NFIELD];
  logic [CW-1:0]        dec_f   [NFIELD];
  logic [CW-1:0]        sum_f   [NFIELD];
  logic [NFIELD-1:0]    ovf_f;
  logic [NFIELD-1:0]    unf_f;
  logic [SELW-1:0]      rd_idx  [NRP];

  // Per-port, per-field write strobes.
  always_comb begin
    for (int p = 0; p < NWP; p++) begin
      for (int f = 0; f < NFIELD; f++) begin
        wr_hit[p][f] = wr_en[p] & wr_mask[p*NFIELD+f];
      end
    end
  end

  // Merge write ports into the next-state CR; ascending loop lets the highest port win.
  always_comb begin
    cr_nxt = cr_q;
    for (int f = 0; f < NFIELD; f++) begin
      for (int p = 0; p < NWP; p++) begin
        if (wr_hit[p][f]) begin
          cr_nxt[f*FW +: FW] = wr_data[(p*NFIELD+f)*FW +: FW];
        end
      end
    end
  end

  // Scoreboard next count: reserve adds one, each writing port releases one, clamp at both ends.
  always_comb begin
    for (int f = 0; f < NFIELD; f++) begin
      dec_f[f] = '0;
      for (int p = 0; p < NWP; p++) begin
        if (wr_hit[p][f]) begin
          dec_f[f] = dec_f[f] + CW'(1);
        end
      end
      sum_f[f] = {2'b00, cnt_q[f]} + CW'(rsv_en & rsv_mask[f]) - dec_f[f];
      // Top bit set means the count went negative (more releases than outstanding).
      unf_f[f] = sum_f[f][CW-1];
      ovf_f[f] = !sum_f[f][CW-1] && (sum_f[f] > CMAX);
      if (unf_f[f]) begin
        cnt_nxt[f] = '0;
      end else if (ovf_f[f]) begin
        cnt_nxt[f] = CMAX[PW-1:0];
      end else begin
        cnt_nxt[f] = sum_f[f][PW-1:0];
      end
    end
  end

  // Register CR, counts and sticky error flags; synchronous reset overrides same-cycle activity.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cr_q    <= '0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
      for (int f = 0; f < NFIELD; f++) begin
        cnt_q[f] <= '0;
      end
    end else begin
      cr_q    <= cr_nxt;
      err_ovf <= err_ovf | (|ovf_f);
      err_unf <= err_unf | (|unf_f);
      for (int f = 0; f < NFIELD; f++) begin
        cnt_q[f] <= cnt_nxt[f];
      end
    end
  end

  // Busy reflects the registered count, so a reservation shows up one cycle later.
  always_comb begin
    for (int f = 0; f < NFIELD; f++) begin
      busy[f] = |cnt_q[f];
    end
  end

  assign cr_all = cr_q;

  // Read ports: forward the merged next-state field; out-of-range selects read as idle zero.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int r = 0; r < NRP; r++) begin
      rd_idx[r] = rd_sel[r*SELW +: SELW];
      if (int'(rd_idx[r]) < NFIELD) begin
        rd_data[r*FW +: FW] = cr_nxt[int'(rd_idx[r])*FW +: FW];
        rd_busy[r]          = busy[rd_idx[r]];
      end
    end
  end

endmodule

// File: tb/tb_cr_field_file.sv
`timescale 1ns/1ps
// Bench for cr_field_file: hand-built vector table for the directed corner cases,
// then randomized traffic against an integer-array reference model.
module tb_cr_field_file;

  localparam int NF  = 8;
  localparam int NWP = 2;
  localparam int NRP = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  wr_en;
  logic [15:0] wr_mask;
  logic [63:0] wr_data;
  logic        rsv_en;
  logic [7:0]  rsv_mask;
  logic [5:0]  rd_sel;
  logic [7:0]  rd_data;
  logic [1:0]  rd_busy;
  logic [31:0] cr_all;
  logic [7:0]  busy;
  logic        err_ovf;
  logic        err_unf;

  always #5 clk = ~clk;

  cr_field_file dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_mask  (wr_mask),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_mask (rsv_mask),
    .rd_sel   (rd_sel),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .cr_all   (cr_all),
    .busy     (busy),
    .err_ovf  (err_ovf),
    .err_unf  (err_unf)
  );

  typedef struct {
    logic        rst_n;
    logic [1:0]  wr_en;
    logic [15:0] wr_mask;
    logic [63:0] wr_data;
    logic        rsv_en;
    logic [7:0]  rsv_mask;
    logic [5:0]  rd_sel;
    logic        chk;
    logic [7:0]  exp_rd;
    logic [1:0]  exp_rdb;
    logic [7:0]  exp_busy;
    logic [31:0] exp_cr;
    logic [1:0]  exp_err;   // {unf, ovf}
  } vec_t;

  vec_t tv [22];

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  int m_fld [NF];
  int m_cnt [NF];
  bit m_unf;
  bit m_ovf;
  int m_nxt [NF];
  int m_dec [NF];

  function automatic logic [51:0] dut_obs();
    return {rd_data, rd_busy, busy, cr_all, err_unf, err_ovf};
  endfunction

  task automatic compare(input string name, input logic [51:0] act, input logic [51:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got rd=%h rdb=%b busy=%h cr=%h err=%b, want rd=%h rdb=%b busy=%h cr=%h err=%b",
               name, act[51:44], act[43:42], act[41:34], act[33:2], act[1:0],
               exp[51:44], exp[43:42], exp[41:34], exp[33:2], exp[1:0]);
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] en, input logic [15:0] msk,
                       input logic [63:0] dat, input logic rv, input logic [7:0] rmsk,
                       input logic [5:0] sel);
    rst_n    = r;
    wr_en    = en;
    wr_mask  = msk;
    wr_data  = dat;
    rsv_en   = rv;
    rsv_mask = rmsk;
    rd_sel   = sel;
  endtask

  // Model: forwarded field values and release counts for the presented inputs.
  task automatic model_eval(output logic [51:0] exp);
    logic [7:0]  e_rd;
    logic [1:0]  e_rdb;
    logic [7:0]  e_busy;
    logic [31:0] e_cr;
    int s;
    for (int f = 0; f < NF; f++) begin
      m_nxt[f] = m_fld[f];
      m_dec[f] = 0;
      for (int p = 0; p < NWP; p++) begin
        if (wr_en[p] && wr_mask[p*NF+f]) begin
          m_nxt[f] = int'(wr_data[(p*NF+f)*4 +: 4]);
          m_dec[f] = m_dec[f] + 1;
        end
      end
      e_busy[f]     = (m_cnt[f] != 0);
      e_cr[f*4 +: 4] = 4'(m_fld[f]);
    end
    for (int r = 0; r < NRP; r++) begin
      s = int'(rd_sel[r*3 +: 3]);
      e_rd[r*4 +: 4] = 4'(m_nxt[s]);
      e_rdb[r]       = (m_cnt[s] != 0);
    end
    exp = {e_rd, e_rdb, e_busy, e_cr, m_unf, m_ovf};
  endtask

  // Model: clock edge update using the same presented inputs.
  task automatic model_step();
    int v;
    for (int f = 0; f < NF; f++) begin
      if (!rst_n) begin
        m_fld[f] = 0;
        m_cnt[f] = 0;
      end else begin
        m_fld[f] = m_nxt[f];
        v = m_cnt[f] + ((rsv_en && rsv_mask[f]) ? 1 : 0) - m_dec[f];
        if (v < 0) begin
          m_cnt[f] = 0;
          m_unf    = 1'b1;
        end else if (v > 3) begin
          m_cnt[f] = 3;
          m_ovf    = 1'b1;
        end else begin
          m_cnt[f] = v;
        end
      end
    end
    if (!rst_n) begin
      m_unf = 1'b0;
      m_ovf = 1'b0;
    end
  endtask

  initial begin
    logic [51:0] exp;

    //         rst   en     mask      data                    rsv   rmask  sel    chk   rd     rdb    busy   cr            err
    tv[0]  = '{1'b0, 2'b11, 16'hFFFF, 64'h55555555_AAAAAAAA, 1'b1, 8'hFF, 6'h00, 1'b0, 8'h00, 2'b00, 8'h00, 32'h00000000, 2'b00};
    tv[1]  = '{1'b0, 2'b11, 16'hFFFF, 64'h55555555_AAAAAAAA, 1'b1, 8'hFF, 6'h00, 1'b1, 8'h55, 2'b00, 8'h00, 32'h00000000, 2'b00};
    tv[2]  = '{1'b1, 2'b00, 16'h0000, 64'h0,                 1'b0, 8'h00, 6'h00, 1'b1, 8'h00, 2'b00, 8'h00, 32'h00000000, 2'b00};
    // two ports hit field0: port1 wins, forwarded same cycle, double release underflows
    tv[3]  = '{1'b1, 2'b11, 16'h0101, 64'h0000000A_00000003, 1'b0, 8'h00, 6'h08, 1'b1, 8'h0A, 2'b00, 8'h00, 32'h00000000, 2'b00};
    tv[4]  = '{1'b1, 2'b00, 16'h0000, 64'h0,                 1'b0, 8'h00, 6'h00, 1'b1, 8'hAA, 2'b00, 8'h00, 32'h0000000A, 2'b10};
    // reserve field2 four times: saturates at 3 and flags overflow
    tv[5]  = '{1'b1, 2'b00, 16'h0000, 64'h0,                 1'b1, 8'h04, 6'h02, 1'b1, 8'hA0, 2'b00, 8'h00, 32'h0000000A, 2'b10};
    tv[6]  = '{1'b1, 2'b00, 16'h0000, 64'h0,                 1'b1, 8'h04, 6'h02, 1'b1, 8'hA0, 2'b01, 8'h04, 32'h0000000A, 2'b10};
    tv[7]  = '{1'b1, 2'b00, 16'h0000, 64'h0,                 1'b1, 8'h04, 6'h02, 1'b1, 8'hA0, 2'b01, 8'h04, 32'h0000000A, 2'b10};
    tv[8]  = '{1'b1, 2'b00, 16'h0000, 64'h0,                 1'b1, 8'h04, 6'h02, 1'b1, 8'hA0, 2'b01, 8'h04, 32'h0000000A, 2'b10};
    // three single-port releases of field2
    tv[9]  = '{1'b1, 2'b01, 16'h0004, 64'h00000000_00000700, 1'b0, 8'h00, 6'h02, 1'b1, 8'hA7, 2'b01, 8'h04, 32'h0000000A, 2'b11};
    tv[10] = '{1'b1, 2'b10, 16'h0400, 64'h00000900_00000000, 1'b0, 8'h00, 6'h02, 1'b1, 8'hA9, 2'b01, 8'h04, 32'h0000070A, 2'b11};
    tv[11] = '{1'b1, 2'b01, 16'h0004, 64'h00000000_00000100, 1'b0, 8'h00, 6'h02, 1'b1, 8'hA1, 2'b01, 8'h04, 32'h0000090A, 2'b11};
    tv[12] = '{1'b1, 2'b00, 16'h0000, 64'h0,                 1'b0, 8'h00, 6'h02, 1'b1, 8'hA1, 2'b00, 8'h00, 32'h0000010A, 2'b11};
    // build count 2 on field1, then reset with a reserve and write in flight
    tv[13] = '{1'b1, 2'b00, 16'h0000, 64'h0,                 1'b1, 8'h02, 6'h01, 1'b1, 8'hA0, 2'b00, 8'h00, 32'h0000010A, 2'b11};
    tv[14] = '{1'b1, 2'b00, 16'h0000, 64'h0,                 1'b1, 8'h02, 6'h01, 1'b1, 8'hA0, 2'b01, 8'h02, 32'h0000010A, 2'b11};
    tv[15] = '{1'b0, 2'b01, 16'h0002, 64'h00000000_00000060, 1'b1, 8'h02, 6'h01, 1'b1, 8'hA6, 2'b01, 8'h02, 32'h0000010A, 2'b11};
    tv[16] = '{1'b1, 2'b00, 16'h0000, 64'h0,                 1'b0, 8'h00, 6'h01, 1'b1, 8'h00, 2'b00, 8'h00, 32'h00000000, 2'b00};
    // count 1 on field5, then reserve + release same cycle: count holds, no error
    tv[17] = '{1'b1, 2'b00, 16'h0000, 64'h0,                 1'b1, 8'h20, 6'h05, 1'b1, 8'h00, 2'b00, 8'h00, 32'h00000000, 2'b00};
    tv[18] = '{1'b1, 2'b01, 16'h0020, 64'h00000000_00C00000, 1'b1, 8'h20, 6'h05, 1'b1, 8'h0C, 2'b01, 8'h20, 32'h00000000, 2'b00};
    tv[19] = '{1'b1, 2'b00, 16'h0000, 64'h0,                 1'b0, 8'h00, 6'h05, 1'b1, 8'h0C, 2'b01, 8'h20, 32'h00C00000, 2'b00};
    // write field7 = F, then hold: read back with no write, other fields untouched
    tv[20] = '{1'b1, 2'b10, 16'h8000, 64'hF0000000_00000000, 1'b0, 8'h00, 6'h2F, 1'b1, 8'hCF, 2'b10, 8'h20, 32'h00C00000, 2'b00};
    tv[21] = '{1'b1, 2'b00, 16'h0000, 64'h0,                 1'b0, 8'h00, 6'h2F, 1'b1, 8'hCF, 2'b10, 8'h20, 32'hF0C00000, 2'b10};

    drive(1'b0, 2'b00, 16'h0, 64'h0, 1'b0, 8'h0, 6'h0);

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      drive(tv[i].rst_n, tv[i].wr_en, tv[i].wr_mask, tv[i].wr_data,
            tv[i].rsv_en, tv[i].rsv_mask, tv[i].rd_sel);
      #1;
      if (tv[i].chk) begin
        compare($sformatf("tbl%0d", i), dut_obs(),
                {tv[i].exp_rd, tv[i].exp_rdb, tv[i].exp_busy, tv[i].exp_cr, tv[i].exp_err});
      end
      @(posedge clk);
    end

    for (int f = 0; f < NF; f++) begin
      m_fld[f] = 0;
      m_cnt[f] = 0;
    end
    m_unf = 1'b0;
    m_ovf = 1'b0;

    // Random traffic: sparse masks keep counts moving both ways, occasional resets clear sticky errors.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      drive((i == 0) ? 1'b0 : ($urandom_range(0, 39) != 0),
            2'($urandom),
            16'($urandom & $urandom & $urandom),
            {$urandom, $urandom},
            1'($urandom),
            8'($urandom & $urandom),
            6'($urandom));
      #1;
      model_eval(exp);
      if (i > 0) begin
        compare($sformatf("rnd%0d", i), dut_obs(), exp);
      end
      @(posedge clk);
      model_step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
